bp_fe_fetch_sequencer: RTL and testbench
========================================

// Module: bp_fe_fetch_sequencer
//
// PURPOSE
//  Next-PC scheduler and stall/replay FSM for the FE.
//  - Sequences fetch PCs into the I$ IF1 stage.
//  - Consumes the IF2 realigner control decode (linear/eager/scan/rebase) and backend redirects.
//  - Applies fetch-queue backpressure through a credit counter.
//  - Sits between bp_fe_realigner (IF2) and the I$ request port (IF1).
//
// PARAMETERS
//  bp_params_p  e_bp_default_cfg  proc config; supplies vaddr_width_p
//  credits_p    4                 fetch-queue entries; credit counter max
//  boot_pc_p    'h0011_0000       PC loaded on leaving reset
//
// PORTS
//  clk_i                 in   1   clock
//  reset_n_i             in   1   async active-low reset
//  redirect_v_i          in   1   backend redirect; highest priority
//  redirect_pc_i         in   VA  redirect target
//  icache_ready_i        in   1   I$ can accept an IF1 request this cycle
//  if2_v_i               in   1   realigner fetch_instr_v
//  if2_pc_i              in   VA  realigner fetch_pc
//  if2_yumi_i            in   1   realigner consumed IF2 data
//  if2_linear_i          in   1   realigner fetch_linear
//  if2_eager_i           in   1   realigner fetch_eager
//  if2_scan_i            in   1   realigner fetch_scan
//  if2_rebase_i          in   1   realigner fetch_rebase
//  pred_taken_i          in   1   BTB/RAS predicted taken at IF2
//  pred_pc_i             in   VA  predicted target
//  credit_return_i       in   1   one fetch-queue entry freed
//  if1_v_o               out  1   IF1 request valid
//  if1_pc_o              out  VA  IF1 request PC (registered)
//  if1_kill_o            out  1   squash in-flight IF1
//  if2_kill_o            out  1   squash in-flight IF2
//  state_o               out  2   bp_fe_seq_state_e, debug
//
// BEHAVIOUR
//  - Reset values (async assert):
//    - state=e_reset, if1_pc_o=boot_pc_p, if1_v_o=0.
//    - Kill outputs 0; credits_r=credits_p.
//  - e_reset -> e_run on the first clock after deassert. if1_v_o=1 from that cycle.
//  - Next-PC priority (one-hot source, bp_fe_seq_src_e). Transfer applies when the IF1 slot advances, i.e. if1_v_o & icache_ready_i; else PC holds.
//    - redirect -> redirect_pc_i. Kills IF1+IF2 combinationally, same cycle; state -> e_run.
//    - rebase -> if2_pc_i+2. Kills IF1.
//    - scan -> if2_pc_i+2. Kills IF1; IF2 held (no yumi).
//    - eager -> if2_pc_i+2.
//    - linear -> {if2_pc_i[VA-1:2],2'b00}+4.
//    - pred_taken_i & if2_v_i -> pred_pc_i. Kills IF1.
//    - default -> {if1_pc_o[VA-1:2],2'b00}+4.
//  - Arithmetic is modulo 2^VA; wrap at the VA top is silent.
//  - Latency: source selected in cycle t -> if1_pc_o valid in t+1.
//  - Credits:
//    - Decrement on if2_yumi_i & if2_v_i; increment on credit_return_i.
//    - Both in the same cycle: no change.
//    - Saturates at credits_p; return at max is ignored (assertion fires).
//  - e_run -> e_stall when credits_r==0, or ~icache_ready_i for 1 cycle while if1_v_o.
//    - In e_stall: if1_v_o=0 and the PC holds.
//  - e_stall -> e_replay when credits_r>0 & icache_ready_i.
//    - e_replay reissues the held PC for 1 cycle, then -> e_run.
//  - Redirect in any state: load PC, go to e_run; credits unaffected.
//  - Redirect during e_reset: ignored.
//  - Async reset mid-operation returns all state to reset values immediately.
//
// CONFIGURATION
//  BP_FE_SEQ_PERF_EN
//    - Defined: adds 32-bit saturating counters (redirect, rebase, scan, stall cycles) and output perf_o[127:0].
//      Counters clear on reset.
//    - Undefined: no counters; perf_o is tied to 0. Control behaviour is identical.
//
// STRUCTURE
//  - Shared in bp_fe_pkg:
//    - bp_fe_seq_state_e {e_reset, e_run, e_stall, e_replay}
//    - bp_fe_seq_src_e (7 sources)
//  - Sub-module bp_fe_seq_npc_mux: combinational priority encode + next-PC adders.
//  - FSM, PC register and credit counter live in the top module.
//
// TESTING
//  1. Reset release, all ready, no IF2 -> if1_pc_o 0x110000, 0x110004, 0x110008 on consecutive cycles.
//  2. Redirect to 0x2002 while if2_linear_i=1 -> if1_kill_o=if2_kill_o=1 same cycle; next if1_pc_o=0x2002.
//  3. if2_pc_i=0x3000, if2_rebase_i=1 -> if1_kill_o=1, next if1_pc_o=0x3002.
//     Same with if2_scan_i=1 -> 0x3002, no kill of IF2.
//  4. credits_p=4, 4 yumis with no return -> e_stall, if1_v_o=0.
//     One credit_return_i -> e_replay reissues the held PC, then e_run.
//  5. Yumi and credit_return_i in the same cycle at 2 credits -> count stays 2, no stall.
//  6. Assert reset_n_i low mid-stall -> state=e_reset, if1_pc_o=boot_pc_p with no clock edge.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared FE types: proc config, fetch-sequencer states, next-PC sources and IF2 control decode.
package bp_fe_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    unique case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  typedef enum logic [1:0] {e_reset, e_run, e_stall, e_replay} bp_fe_seq_state_e;

  // One-hot next-PC source, listed from highest to lowest priority
  typedef enum logic [6:0] {
    e_src_redirect = 7'b000_0001,
    e_src_rebase   = 7'b000_0010,
    e_src_scan     = 7'b000_0100,
    e_src_eager    = 7'b000_1000,
    e_src_linear   = 7'b001_0000,
    e_src_pred     = 7'b010_0000,
    e_src_seq      = 7'b100_0000
  } bp_fe_seq_src_e;

  typedef struct packed {
    logic rebase;
    logic scan;
    logic eager;
    logic linear;
  } bp_fe_if2_ctrl_s;

endpackage

// File: rtl/bp_fe_seq_npc_mux.sv
// Priority-encodes the next-PC source and forms the candidate fetch PC; purely combinational.
module bp_fe_seq_npc_mux
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39
) (
  input  logic                     redirect_v,
  input  logic [vaddr_width_p-1:0] redirect_pc,
  input  bp_fe_if2_ctrl_s          if2_ctrl,
  input  logic [vaddr_width_p-1:0] if2_pc,
  input  logic                     pred_v,
  input  logic [vaddr_width_p-1:0] pred_pc,
  input  logic [vaddr_width_p-1:0] if1_pc,
  output bp_fe_seq_src_e           src,
  output logic [vaddr_width_p-1:0] npc
);

  logic [vaddr_width_p-1:0] if2_half, if2_word, if1_word;

  // Sums wrap silently at the top of the VA space
  assign if2_half = if2_pc + vaddr_width_p'(2);
  assign if2_word = {if2_pc[vaddr_width_p-1:2], 2'b00} + vaddr_width_p'(4);
  assign if1_word = {if1_pc[vaddr_width_p-1:2], 2'b00} + vaddr_width_p'(4);

  always_comb begin
    src = e_src_seq;
    npc = if1_word;
    if (redirect_v) begin
      src = e_src_redirect;
      npc = redirect_pc;
    end else if (if2_ctrl.rebase) begin
      src = e_src_rebase;
      npc = if2_half;
    end else if (if2_ctrl.scan) begin
      src = e_src_scan;
      npc = if2_half;
    end else if (if2_ctrl.eager) begin
      src = e_src_eager;
      npc = if2_half;
    end else if (if2_ctrl.linear) begin
      src = e_src_linear;
      npc = if2_word;
    end else if (pred_v) begin
      src = e_src_pred;
      npc = pred_pc;
    end
  end

endmodule

// File: rtl/bp_fe_fetch_sequencer.sv
// FE next-PC scheduler with stall/replay FSM and fetch-queue credit counter.
// Define BP_FE_SEQ_PERF_EN to add saturating perf counters on perf_o.
module bp_fe_fetch_sequencer
  import bp_fe_pkg::*;
#(
  parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
  parameter int          credits_p     = 4,
  parameter logic [63:0] boot_pc_p     = 64'h0011_0000,
  localparam int         vaddr_width_p = bp_vaddr_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  input  logic                     icache_ready_i,
  input  logic                     if2_v_i,
  input  logic [vaddr_width_p-1:0] if2_pc_i,
  input  logic                     if2_yumi_i,
  input  logic                     if2_linear_i,
  input  logic                     if2_eager_i,
  input  logic                     if2_scan_i,
  input  logic                     if2_rebase_i,
  input  logic                     pred_taken_i,
  input  logic [vaddr_width_p-1:0] pred_pc_i,
  input  logic                     credit_return_i,
  output logic                     if1_v_o,
  output logic [vaddr_width_p-1:0] if1_pc_o,
  output logic                     if1_kill_o,
  output logic                     if2_kill_o,
  output logic [1:0]               state_o,
  output logic [127:0]             perf_o
);

  localparam int                       cw_lp          = $clog2(credits_p + 1);
  localparam logic [cw_lp-1:0]         credits_max_lp = cw_lp'(credits_p);
  localparam logic [vaddr_width_p-1:0] boot_pc_lp     = boot_pc_p[vaddr_width_p-1:0];

  bp_fe_seq_state_e         state_r, state_n;
  bp_fe_seq_src_e           src;
  bp_fe_if2_ctrl_s          if2_ctrl;
  logic [vaddr_width_p-1:0] pc_r, npc;
  logic [cw_lp-1:0]         credits_r;
  logic                     live, adv, credit_dec;

  assign if2_ctrl = '{rebase: if2_rebase_i, scan: if2_scan_i,
                      eager: if2_eager_i, linear: if2_linear_i};

  bp_fe_seq_npc_mux #(.vaddr_width_p(vaddr_width_p)) npc_mux (
    .redirect_v  (redirect_v_i),
    .redirect_pc (redirect_pc_i),
    .if2_ctrl    (if2_ctrl),
    .if2_pc      (if2_pc_i),
    .pred_v      (pred_taken_i & if2_v_i),
    .pred_pc     (pred_pc_i),
    .if1_pc      (pc_r),
    .src         (src),
    .npc         (npc)
  );

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= e_reset;
    else            state_r <= state_n;

  always_comb begin
    state_n = state_r;
    if1_v_o = 1'b0;
    unique case (state_r)
      e_reset:  state_n = e_run;
      e_run: begin
        if1_v_o = 1'b1;
        if (credits_r == '0 || !icache_ready_i) state_n = e_stall;
      end
      e_stall:  if (credits_r != '0 && icache_ready_i) state_n = e_replay;
      e_replay: begin
        if1_v_o = 1'b1;
        state_n = e_run;
      end
    endcase
    if (redirect_v_i && state_r != e_reset) state_n = e_run;
  end

  // Nothing is steered until the first clock after reset release
  assign live       = (state_r != e_reset);
  assign adv        = if1_v_o & icache_ready_i;
  assign if1_kill_o = live & (src inside {e_src_redirect, e_src_rebase, e_src_scan, e_src_pred});
  assign if2_kill_o = live & (src == e_src_redirect);
  assign if1_pc_o   = pc_r;
  assign state_o    = state_r;

  // Redirect loads regardless of I$ readiness; everything else waits for the slot to advance
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)                      pc_r <= boot_pc_lp;
    else if (live & (redirect_v_i | adv)) pc_r <= npc;

  assign credit_dec = if2_yumi_i & if2_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)
      credits_r <= credits_max_lp;
    else if (credit_dec && !credit_return_i && credits_r != '0)
      credits_r <= credits_r - cw_lp'(1);
    else if (credit_return_i && !credit_dec && credits_r != credits_max_lp)
      credits_r <= credits_r + cw_lp'(1);

  // A return into a full queue means upstream lost track of an entry
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(credit_return_i && !credit_dec && credits_r == credits_max_lp));

`ifdef BP_FE_SEQ_PERF_EN
  logic [3:0]  perf_inc;
  logic [31:0] perf_r [4];

  assign perf_inc = {state_r == e_stall, adv & (src == e_src_scan),
                     adv & (src == e_src_rebase), live & redirect_v_i};

  for (genvar i = 0; i < 4; i++) begin : g_perf
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i)                       perf_r[i] <= '0;
      else if (perf_inc[i] && ~&perf_r[i]) perf_r[i] <= perf_r[i] + 32'd1;
  end

  assign perf_o = {perf_r[3], perf_r[2], perf_r[1], perf_r[0]};
`else
  assign perf_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// Bench for bp_fe_fetch_sequencer: directed table, multi-cycle sequences and a random run against a reference model.
module tb_bp_fe_fetch_sequencer;
  import bp_fe_pkg::*;

  localparam int VA = 39;
  localparam logic [VA-1:0] BOOT = 39'h11_0000;
  localparam int CRED = 4;
  localparam int S_RESET = 0, S_RUN = 1, S_STALL = 2, S_REPLAY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redir_v, ready, if2_v, yumi, lin, eag, scn, reb, pt, ret;
  logic [VA-1:0] redir_pc, if2_pc, ppc;
  logic if1_v, k1, k2;
  logic [VA-1:0] if1_pc;
  logic [1:0] st;
  logic [127:0] perf;

  int checks = 0;
  int failures = 0;

  int m_st, m_cr;
  logic [VA-1:0] m_pc;

  always #5 clk = ~clk;

  bp_fe_fetch_sequencer #(.credits_p(CRED), .boot_pc_p(64'h0011_0000)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .redirect_v_i(redir_v), .redirect_pc_i(redir_pc), .icache_ready_i(ready),
    .if2_v_i(if2_v), .if2_pc_i(if2_pc), .if2_yumi_i(yumi),
    .if2_linear_i(lin), .if2_eager_i(eag), .if2_scan_i(scn), .if2_rebase_i(reb),
    .pred_taken_i(pt), .pred_pc_i(ppc), .credit_return_i(ret),
    .if1_v_o(if1_v), .if1_pc_o(if1_pc), .if1_kill_o(k1), .if2_kill_o(k2),
    .state_o(st), .perf_o(perf)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: sources listed in priority order, first requested one wins
  function automatic int sel_src();
    bit req [7];
    req = '{redir_v, reb, scn, eag, lin, pt & if2_v, 1'b1};
    for (int i = 0; i < 7; i++) if (req[i]) return i;
    return 6;
  endfunction

  function automatic logic [VA-1:0] src_target(int s);
    case (s)
      0:       return redir_pc;
      1, 2, 3: return if2_pc + VA'(2);
      4:       return (if2_pc & ~VA'(3)) + VA'(4);
      5:       return ppc;
      default: return (m_pc & ~VA'(3)) + VA'(4);
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_RESET; m_pc = BOOT; m_cr = CRED;
  endtask

  task automatic model_check();
    bit live;
    int s;
    live = (m_st != S_RESET);
    s = sel_src();
    chk("m_state", 64'(st), 64'(m_st));
    chk("m_if1_v", 64'(if1_v), 64'(m_st == S_RUN || m_st == S_REPLAY));
    chk("m_if1_pc", 64'(if1_pc), 64'(m_pc));
    chk("m_if1_kill", 64'(k1), 64'(live && (s == 0 || s == 1 || s == 2 || s == 5)));
    chk("m_if2_kill", 64'(k2), 64'(live && s == 0));
  endtask

  task automatic model_step();
    bit live, adv, dec;
    int nst;
    if (!rst_n) begin model_reset(); return; end
    live = (m_st != S_RESET);
    adv = (m_st == S_RUN || m_st == S_REPLAY) && ready;
    nst = m_st;
    case (m_st)
      S_RESET:  nst = S_RUN;
      S_RUN:    if (m_cr == 0 || !ready) nst = S_STALL;
      S_STALL:  if (m_cr > 0 && ready) nst = S_REPLAY;
      default:  nst = S_RUN;
    endcase
    if (live && redir_v) nst = S_RUN;
    if ((live && redir_v) || adv) m_pc = src_target(sel_src());
    dec = yumi && if2_v;
    if (dec && !ret && m_cr > 0) m_cr--;
    else if (ret && !dec && m_cr < CRED) m_cr++;
    m_st = nst;
  endtask

  // Entered just after a rising edge; checks mid-cycle, then advances one clock
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    redir_v = 0; redir_pc = '0; ready = 1; if2_v = 0; if2_pc = '0; yumi = 0;
    lin = 0; eag = 0; scn = 0; reb = 0; pt = 0; ppc = '0; ret = 0;
  endtask

  function automatic logic [VA-1:0] rnd_va();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VA-1:0];
  endfunction

  typedef struct {
    string nm;
    logic [VA-1:0] base, rpc, i2pc, pc_pred, exp;
    bit rv, i2v, rb, sc, eg, ln, p, ek1, ek2;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, logic [VA-1:0] base, bit rv, logic [VA-1:0] rpc,
                              logic [VA-1:0] i2pc, bit i2v, bit rb, bit sc, bit eg, bit ln,
                              bit p, logic [VA-1:0] pc_pred, bit ek1, bit ek2, logic [VA-1:0] exp);
    vec_t v;
    v.nm = nm; v.base = base; v.rv = rv; v.rpc = rpc; v.i2pc = i2pc; v.i2v = i2v;
    v.rb = rb; v.sc = sc; v.eg = eg; v.ln = ln; v.p = p; v.pc_pred = pc_pred;
    v.ek1 = ek1; v.ek2 = ek2; v.exp = exp;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name          base            rv rpc        i2pc            i2v rb sc eg ln p  ppc        k1 k2 exp
    vt.push_back(mk("redir_lin",  39'h5000, 1, 39'h2002, 39'h3000, 0, 0, 0, 0, 1, 0, 39'h0,    1, 1, 39'h2002));
    vt.push_back(mk("rebase",     39'h5000, 0, 39'h0,    39'h3000, 0, 1, 0, 0, 0, 0, 39'h0,    1, 0, 39'h3002));
    vt.push_back(mk("scan",       39'h5000, 0, 39'h0,    39'h3000, 0, 0, 1, 0, 0, 0, 39'h0,    1, 0, 39'h3002));
    vt.push_back(mk("eager",      39'h5000, 0, 39'h0,    39'h3000, 0, 0, 0, 1, 0, 0, 39'h0,    0, 0, 39'h3002));
    vt.push_back(mk("linear",     39'h5000, 0, 39'h0,    39'h3003, 0, 0, 0, 0, 1, 0, 39'h0,    0, 0, 39'h3004));
    vt.push_back(mk("pred",       39'h5000, 0, 39'h0,    39'h3000, 1, 0, 0, 0, 0, 1, 39'h8000, 1, 0, 39'h8000));
    vt.push_back(mk("pred_no_v",  39'h5000, 0, 39'h0,    39'h3000, 0, 0, 0, 0, 0, 1, 39'h8000, 0, 0, 39'h5004));
    vt.push_back(mk("reb_ovr_p",  39'h5000, 0, 39'h0,    39'h3000, 1, 1, 0, 0, 0, 1, 39'h8000, 1, 0, 39'h3002));
    vt.push_back(mk("scan_ovr_e", 39'h5000, 0, 39'h0,    39'h3000, 0, 0, 1, 1, 0, 0, 39'h0,    1, 0, 39'h3002));
    vt.push_back(mk("eag_ovr_l",  39'h5000, 0, 39'h0,    39'h3001, 0, 0, 0, 1, 1, 0, 39'h0,    0, 0, 39'h3003));
    vt.push_back(mk("lin_ovr_p",  39'h5000, 0, 39'h0,    39'h3000, 1, 0, 0, 0, 1, 1, 39'h8000, 0, 0, 39'h3004));
    vt.push_back(mk("seq",        39'h5000, 0, 39'h0,    39'h3000, 0, 0, 0, 0, 0, 0, 39'h0,    0, 0, 39'h5004));
    vt.push_back(mk("seq_wrap",   39'h7F_FFFF_FFFC, 0, 39'h0, 39'h0, 0, 0, 0, 0, 0, 0, 39'h0,  0, 0, 39'h0));
    vt.push_back(mk("eager_wrap", 39'h5000, 0, 39'h0, 39'h7F_FFFF_FFFF, 0, 0, 0, 1, 0, 0, 39'h0, 0, 0, 39'h1));

    // Reset values, with a redirect held that must be ignored
    idle();
    model_reset();
    redir_v = 1; redir_pc = 39'h9000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(st), 64'(S_RESET));
    chk("rst_if1_v", 64'(if1_v), 64'd0);
    chk("rst_pc", 64'(if1_pc), 64'(BOOT));
    chk("rst_kill1", 64'(k1), 64'd0);
    chk("rst_kill2", 64'(k2), 64'd0);
    rst_n = 1;
    tick();
    idle();
    chk("boot_state", 64'(st), 64'(S_RUN));
    chk("boot_v", 64'(if1_v), 64'd1);
    chk("boot_pc0", 64'(if1_pc), 64'h11_0000);
    tick();
    chk("boot_pc1", 64'(if1_pc), 64'h11_0004);
    tick();
    chk("boot_pc2", 64'(if1_pc), 64'h11_0008);

    // Source priority, kills and next PC
    foreach (vt[i]) begin
      idle(); redir_v = 1; redir_pc = vt[i].base;
      tick();
      idle();
      redir_v = vt[i].rv; redir_pc = vt[i].rpc; if2_pc = vt[i].i2pc; if2_v = vt[i].i2v;
      reb = vt[i].rb; scn = vt[i].sc; eag = vt[i].eg; lin = vt[i].ln; pt = vt[i].p; ppc = vt[i].pc_pred;
      #1;
      chk({vt[i].nm, "/if1_kill"}, 64'(k1), 64'(vt[i].ek1));
      chk({vt[i].nm, "/if2_kill"}, 64'(k2), 64'(vt[i].ek2));
      tick();
      chk({vt[i].nm, "/npc"}, 64'(if1_pc), 64'(vt[i].exp));
    end

    // Credit exhaustion, stall, return, replay
    idle(); redir_v = 1; redir_pc = 39'h7000;
    tick();
    idle(); if2_v = 1; yumi = 1;
    repeat (4) tick();
    idle();
    chk("cr0_state", 64'(st), 64'(S_RUN));
    chk("cr0_pc", 64'(if1_pc), 64'h7010);
    tick();
    chk("stall_state", 64'(st), 64'(S_STALL));
    chk("stall_v", 64'(if1_v), 64'd0);
    chk("stall_pc", 64'(if1_pc), 64'h7014);
    tick();
    chk("stall_hold_pc", 64'(if1_pc), 64'h7014);
    ret = 1;
    tick();
    ret = 0;
    chk("ret_state", 64'(st), 64'(S_STALL));
    tick();
    chk("replay_state", 64'(st), 64'(S_REPLAY));
    chk("replay_v", 64'(if1_v), 64'd1);
    chk("replay_pc", 64'(if1_pc), 64'h7014);
    tick();
    chk("post_replay_state", 64'(st), 64'(S_RUN));
    chk("post_replay_pc", 64'(if1_pc), 64'h7018);

    // Yumi and return together at two credits: count holds
    ret = 1;
    tick();
    if2_v = 1; yumi = 1; ret = 1;
    tick();
    ret = 0;
    tick();
    tick();
    idle();
    chk("both_run", 64'(st), 64'(S_RUN));
    tick();
    chk("both_stall", 64'(st), 64'(S_STALL));
    ret = 1;
    tick();
    tick();
    idle();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      redir_v = ($urandom_range(15) == 0);
      redir_pc = rnd_va();
      ready = ($urandom_range(7) != 0);
      if2_v = $urandom_range(1);
      if2_pc = rnd_va();
      yumi = $urandom_range(1);
      reb = ($urandom_range(7) == 0);
      scn = ($urandom_range(7) == 0);
      eag = ($urandom_range(7) == 0);
      lin = ($urandom_range(7) == 0);
      pt = ($urandom_range(3) == 0);
      ppc = rnd_va();
      ret = ($urandom_range(4) == 0) && (m_cr < CRED || (yumi && if2_v));
      tick();
    end

    // Async reset in the middle of a stall
    idle(); ready = 0;
    tick();
    tick();
    chk("pre_rst_stall", 64'(st), 64'(S_STALL));
    rst_n = 0;
    #1;
    chk("async_state", 64'(st), 64'(S_RESET));
    chk("async_pc", 64'(if1_pc), 64'(BOOT));
    chk("async_v", 64'(if1_v), 64'd0);
    model_reset();
    tick();
    rst_n = 1;
    idle();
    tick();
    tick();
    chk("rerun_pc", 64'(if1_pc), 64'h11_0004);

    chk("perf_lo", perf[63:0], 64'd0);
    chk("perf_hi", perf[127:64], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
